// File: rtl/reg_vec_arbiter.sv
// Shared NLANE-bit register vector written by NREQ requesters through a
// round-robin arbiter with an optional per-requester lock for bursts.
module reg_vec_arbiter #(
  parameter int NREQ  = 4,
  parameter int NLANE = 2,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ*NLANE-1:0] req_data,
  input  logic [NREQ*NLANE-1:0] req_mask,
  output logic [NREQ-1:0]       req_ready,
  output logic [NLANE-1:0]      vec_out,
  output logic                  grant_valid,
  output logic [IDW-1:0]        grant_id
);

  logic [NLANE-1:0] vec;
  logic [IDW-1:0]   rr_ptr;
  logic             lock_active;
  logic [IDW-1:0]   lock_owner;

  logic [IDW-1:0]   gnt;
  logic             xfer;
  logic [NLANE-1:0] data_g;
  logic [NLANE-1:0] mask_g;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt  = '0;
    xfer = 1'b0;
    if (reset && !clr) begin
      if (lock_active && req_valid[lock_owner]) begin
        gnt  = lock_owner;
        xfer = 1'b1;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (!xfer && req_valid[wrap_inc(rr_ptr, k)]) begin
            gnt  = wrap_inc(rr_ptr, k);
            xfer = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt] = 1'b1;
  end

  assign data_g  = req_data[int'(gnt)*NLANE +: NLANE];
  assign mask_g  = req_mask[int'(gnt)*NLANE +: NLANE];
  assign vec_out = vec;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec         <= '0;
      rr_ptr      <= '0;
      lock_active <= 1'b0;
      lock_owner  <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else if (clr) begin
      vec         <= '0;
      lock_active <= 1'b0;
      grant_valid <= 1'b0;
    end else if (xfer) begin
      vec         <= (vec & ~mask_g) | (data_g & mask_g);
      rr_ptr      <= wrap_inc(gnt, 1);
      lock_active <= req_lock[gnt];
      lock_owner  <= gnt;
      grant_valid <= 1'b1;
      grant_id    <= gnt;
    end else begin
      grant_valid <= 1'b0;
      // An owner that withdrew its request gives up the lock.
      if (lock_active && !req_valid[lock_owner]) lock_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_vec_arbiter.sv
// Self-checking bench for reg_vec_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbitration rules.
module tb_reg_vec_arbiter;
  localparam int NREQ = 4, NLANE = 2, IDW = 2;

  logic clk = 1'b0, reset = 1'b0, clr = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_lock = '0, req_ready;
  logic [NREQ*NLANE-1:0] req_data = '0, req_mask = '0;
  logic [NLANE-1:0] vec_out;
  logic grant_valid;
  logic [IDW-1:0] grant_id;

  int checks = 0, failures = 0;

  // Behavioural model state
  int m_vec, m_ptr, m_owner, m_gv, m_gid;

  reg_vec_arbiter #(.NREQ(NREQ), .NLANE(NLANE), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_data(req_data), .req_mask(req_mask),
    .req_ready(req_ready), .vec_out(vec_out),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant();
    if (!reset || clr) return -1;
    if (m_owner >= 0 && req_valid[m_owner]) return m_owner;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = exp_grant();
    return (g < 0) ? '0 : NREQ'(1 << g);
  endfunction

  task automatic model_reset();
    m_vec = 0; m_ptr = 0; m_owner = -1; m_gv = 0; m_gid = 0;
  endtask

  // One clock edge; model follows the inputs that were stable before it.
  task automatic tick();
    int g, d, m;
    g = exp_grant();
    @(posedge clk);
    if (clr) begin
      m_vec = 0; m_owner = -1; m_gv = 0;
    end else if (g >= 0) begin
      d = int'(req_data[g*NLANE +: NLANE]);
      m = int'(req_mask[g*NLANE +: NLANE]);
      m_vec   = (m_vec & ~m & 3) | (d & m);
      m_ptr   = (g + 1) % NREQ;
      m_gv    = 1;
      m_gid   = g;
      m_owner = req_lock[g] ? g : -1;
    end else begin
      m_gv = 0;
      if (m_owner >= 0 && !req_valid[m_owner]) m_owner = -1;
    end
    #1;
  endtask

  task automatic set_req(int i, logic [1:0] d, logic [1:0] m);
    req_data[i*NLANE +: NLANE] = d;
    req_mask[i*NLANE +: NLANE] = m;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #12;
    checks++;
    if (req_ready !== 4'b0000 || vec_out !== 2'b00 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: ready=%b vec=%b gv=%b gid=%0d required 0000/00/0/0",
               req_ready, vec_out, grant_valid, grant_id);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++; $display("FAIL idle_ready: got %b required 0000", req_ready);
      end
      tick();
      checks++;
      if (grant_valid !== 1'b0 || vec_out !== 2'b00) begin
        failures++; $display("FAIL idle_out: gv=%b vec=%b required 0/00", grant_valid, vec_out);
      end
    end
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 1, 2, 3, 0};
    req_valid = 4'b1111; req_lock = '0; req_mask = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== NREQ'(1 << seq[c])) begin
        failures++; $display("FAIL rr_ready[%0d]: got %b required grant to %0d", c, req_ready, seq[c]);
      end
      tick();
      checks++;
      if (grant_valid !== 1'b1 || int'(grant_id) != seq[c]) begin
        failures++; $display("FAIL rr_gid[%0d]: gv=%b gid=%0d required 1/%0d", c, grant_valid, grant_id, seq[c]);
      end
    end
  endtask

  task automatic test_masked_write();
    req_valid = 4'b0010; req_mask = '0;
    set_req(1, 2'b11, 2'b11);
    tick();
    checks++;
    if (vec_out !== 2'b11) begin
      failures++; $display("FAIL mw_setup: vec=%b required 11", vec_out);
    end
    set_req(1, 2'b00, 2'b10);
    tick();
    checks++;
    if (vec_out !== 2'b01) begin
      failures++; $display("FAIL masked_write: vec=%b required 01", vec_out);
    end
  endtask

  task automatic test_lock_burst();
    int seq[4] = '{2, 2, 2, 0};
    req_valid = 4'b0101; req_mask = '0;
    for (int c = 0; c < 4; c++) begin
      req_lock = (c < 2) ? 4'b0100 : 4'b0000;
      #1;
      checks++;
      if (req_ready !== NREQ'(1 << seq[c])) begin
        failures++; $display("FAIL lock_ready[%0d]: got %b required grant to %0d", c, req_ready, seq[c]);
      end
      tick();
    end
    checks++;
    if (grant_id !== 2'd0) begin
      failures++; $display("FAIL lock_release_gid: got %0d required 0", grant_id);
    end
  endtask

  task automatic test_clr();
    req_valid = 4'b0001; req_lock = 4'b0001; req_mask = '0;
    set_req(0, 2'b11, 2'b01);
    tick();
    clr = 1'b1;
    set_req(0, 2'b11, 2'b11);
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL clr_ready: got %b required 0000", req_ready);
    end
    tick();
    checks++;
    if (vec_out !== 2'b00 || grant_valid !== 1'b0) begin
      failures++; $display("FAIL clr_vec: vec=%b gv=%b required 00/0", vec_out, grant_valid);
    end
    clr = 1'b0; req_valid = 4'b0011; req_lock = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL clr_lock: got %b required 0010", req_ready);
    end
    tick();
  endtask

  task automatic test_async_reset();
    req_valid = 4'b1000; req_lock = 4'b1000; req_mask = '0;
    set_req(3, 2'b11, 2'b11);
    tick();
    req_valid = 4'b1100; req_lock = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++; $display("FAIL burst_lock: got %b required 1000", req_ready);
    end
    tick();
    checks++;
    if (vec_out !== 2'b11) begin
      failures++; $display("FAIL burst_vec: vec=%b required 11", vec_out);
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (vec_out !== 2'b00 || req_ready !== 4'b0000 || grant_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset: vec=%b ready=%b gv=%b required 00/0000/0", vec_out, req_ready, grant_valid);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL post_reset_grant: got %b required 0100", req_ready);
    end
    tick();
    checks++;
    if (grant_id !== 2'd2 || grant_valid !== 1'b1) begin
      failures++; $display("FAIL post_reset_gid: gid=%0d gv=%b required 2/1", grant_id, grant_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      req_lock  = NREQ'($urandom);
      req_data  = (NREQ*NLANE)'($urandom);
      req_mask  = (NREQ*NLANE)'($urandom);
      clr       = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        failures++; $display("FAIL rand_ready[%0d]: got %b required %b", c, req_ready, exp_ready());
      end
      tick();
      checks++;
      if (int'(vec_out) != m_vec || int'(grant_valid) != m_gv || int'(grant_id) != m_gid) begin
        failures++;
        $display("FAIL rand_out[%0d]: vec=%b gv=%b gid=%0d required %0d/%0d/%0d",
                 c, vec_out, grant_valid, grant_id, m_vec, m_gv, m_gid);
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_masked_write();
    test_lock_burst();
    test_clr();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
